magic_packet_checker: RTL

- Companion to the magic-packet tracker in FIFO formal harnesses; sits on both sides of it.
- Upstream: chooses when the magic packet enters and drives the tracker's `captured` input.
- Downstream: consumes the tracker's `cnt`, detects the cycle the magic packet leaves the FIFO, and checks its data and latency.
- Produces the single safety bit (`prop_ok`) asserted by the formal harness.

---
 rtl/magic_packet_checker.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/magic_packet_checker.sv
// magic_packet_checker: companion to the FIFO magic-packet tracker in formal harnesses.
// Upstream it picks the cycle the magic packet enters the FIFO and raises `captured`;
// downstream it watches the tracker count to spot the packet leaving, then checks its
// data and latency. `prop_ok` is the single safety bit the harness asserts.
//
// Optional feature: define MPC_PROTOCOL_CHECK_EN to turn push-while-full and
// pop-while-empty into an immediate failure. Without it, `full` and `empty` are unused.
module magic_packet_checker #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned CNTWID  = $clog2(DEPTH) + 1,
  parameter int unsigned MAX_LAT = 64,
  parameter int unsigned LATWID  = $clog2(MAX_LAT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [WIDTH-1:0]  data_out,
  input  logic              start,
  input  logic [CNTWID-1:0] cnt,
  input  logic              full,
  input  logic              empty,
  output logic              captured,
  output logic [WIDTH-1:0]  magic_data,
  output logic [1:0]        state,
  output logic [LATWID-1:0] lat,
  output logic              done,
  output logic              err,
  output logic              prop_ok
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2,
    StFail = 2'd3
  } state_e;

  localparam logic [CNTWID-1:0] CntDepth = CNTWID'(DEPTH);
  localparam logic [CNTWID-1:0] CntOne   = CNTWID'(1);
  localparam logic [LATWID-1:0] LatLast  = LATWID'(MAX_LAT - 1);
  localparam logic [LATWID-1:0] LatMax   = LATWID'(MAX_LAT);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    magic_q, magic_d;
  logic [LATWID-1:0]   lat_q, lat_d;

  logic cnt_zero;
  logic cnt_one;
  logic capture;
  logic exit_ev;
  logic underflow;
  logic lat_bound;
  logic proto_fail;
  logic live;

  assign cnt_zero  = (cnt == '0);
  assign cnt_one   = (cnt == CntOne);
  // A same-cycle pop at cnt==0 would pop the magic packet before it exists.
  assign capture   = start & push & (cnt < CntDepth) & ~(pop & cnt_zero);
  assign exit_ev   = pop & cnt_one;
  assign underflow = pop & cnt_zero;
  assign lat_bound = (lat_q == LatLast);
  assign live      = (state_q == StIdle) || (state_q == StWait);

`ifdef MPC_PROTOCOL_CHECK_EN
  assign proto_fail = live & ((push & full) | (pop & empty));
`else
  // Flags are only meaningful when the protocol check is built in.
  logic unused_flags;
  assign unused_flags = full ^ empty;
  assign proto_fail   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; protocol violations override every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (capture) state_d = StWait;
      end
      StWait: begin
        if (exit_ev) begin
          state_d = (data_out == magic_q) ? StDone : StFail;
        end else if (underflow) begin
          state_d = StFail;
        end else if (lat_bound) begin
          state_d = StFail;
        end
      end
      StDone: state_d = StDone;
      StFail: state_d = StFail;
    endcase
    if (proto_fail) state_d = StFail;
  end

  // Captured value and latency counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      magic_q <= '0;
      lat_q   <= '0;
    end else begin
      magic_q <= magic_d;
      lat_q   <= lat_d;
    end
  end

  // Datapath next-state: load on capture, count only on quiet WAIT cycles.
  always_comb begin
    magic_d = magic_q;
    lat_d   = lat_q;
    if (!proto_fail) begin
      if (state_q == StIdle && capture) begin
        magic_d = data_in;
        lat_d   = '0;
      end else if (state_q == StWait && !(exit_ev || underflow) && !lat_bound) begin
        lat_d = (lat_q == LatMax) ? lat_q : lat_q + LATWID'(1);
      end
    end
  end

  // Outputs decoded from the registered state only, so `pop` never reaches `err`
  // combinationally.
  always_comb begin
    captured = (state_q != StIdle);
    done     = (state_q == StDone);
    err      = (state_q == StFail);
    prop_ok  = ~err;
  end

  assign state      = state_q;
  assign lat        = lat_q;
  assign magic_data = magic_q;

endmodule
